// File: rtl/gate_vector_sequencer_pkg.sv
// Shared definitions for the gate self-test sequencer: function codes, FSM
// encoding and the reference gate evaluation used by the checker.
package gate_test_pkg;

  localparam logic [2:0] FN_AND  = 3'd0;
  localparam logic [2:0] FN_OR   = 3'd1;
  localparam logic [2:0] FN_NAND = 3'd2;
  localparam logic [2:0] FN_NOR  = 3'd3;
  localparam logic [2:0] FN_XOR  = 3'd4;
  localparam logic [2:0] FN_XNOR = 3'd5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int MAX_IN = 6;

  function automatic logic fn_illegal(input logic [2:0] fs);
    return (fs > FN_XNOR);
  endfunction

  // Only the low n bits of v take part; reserved codes evaluate to 0.
  function automatic logic fn_eval(input logic [2:0] fs, input logic [MAX_IN-1:0] v,
                                   input int n);
    logic a, o, x;
    a = 1'b1;
    o = 1'b0;
    x = 1'b0;
    for (int i = 0; i < MAX_IN; i++) begin
      if (i < n) begin
        a = a & v[i];
        o = o | v[i];
        x = x ^ v[i];
      end
    end
    case (fs)
      FN_AND:  return a;
      FN_OR:   return o;
      FN_NAND: return ~a;
      FN_NOR:  return ~o;
      FN_XOR:  return x;
      FN_XNOR: return ~x;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gate_vector_sequencer_if.sv
// Control, observation and cell-facing signals of the gate sequencer.
interface gate_vector_sequencer_if #(parameter int N_IN = 3);
    logic            start;
    logic [2:0]      func_sel;
    logic [N_IN-1:0] vec_out;
    logic            dut_zn;
    logic            busy;
    logic            sample_valid;
    logic [N_IN-1:0] sample_vec;
    logic            sample_zn;
    logic            sample_exp;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;

    modport master (
        output start, func_sel, dut_zn,
        input  vec_out, busy, sample_valid, sample_vec, sample_zn, sample_exp,
               done, pass, err_count
    );

    modport slave (
        input  start, func_sel, dut_zn,
        output vec_out, busy, sample_valid, sample_vec, sample_zn, sample_exp,
               done, pass, err_count
    );
endinterface

// File: rtl/gate_vector_sequencer_ref_model.sv
// Combinational reference gate: expected ZN for a vector under a function code.
module gate_ref_model
    import gate_test_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic [2:0]      func_sel,
    input  logic [N_IN-1:0] vec,
    output logic            exp,
    output logic            illegal
);
    logic [MAX_IN-1:0] vec_ext;

    assign vec_ext = MAX_IN'(vec);
    assign illegal = fn_illegal(func_sel);
    assign exp     = illegal ? 1'b0 : fn_eval(func_sel, vec_ext, N_IN);
endmodule

// File: rtl/gate_vector_sequencer.sv
// Walks every input vector of a gate under test, holds each for SETTLE cycles,
// samples ZN against the reference function and tallies mismatches.
module gate_vector_sequencer
    import gate_test_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 10
) (
    input logic                    clk,
    input logic                    rst,
    gate_vector_sequencer_if.slave bus
);
    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE);

    logic [1:0]      state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      fs_q, fs_d;
    logic            cfg_err_q, cfg_err_d;
    logic [N_IN:0]   err_q, err_d;
    logic            pass_q, pass_d;
    logic            sv_q, sv_d;
    logic [N_IN-1:0] svec_q, svec_d;
    logic            szn_q, szn_d;
    logic            sexp_q, sexp_d;

    logic exp_w, illegal_w, mismatch;

    gate_ref_model #(.N_IN(N_IN)) u_ref (
        .func_sel (fs_q),
        .vec      (vec_q),
        .exp      (exp_w),
        .illegal  (illegal_w)
    );

    // Case inequality so an X/Z on the cell output is scored as a failure.
    assign mismatch = (bus.dut_zn !== exp_w);

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        fs_d      = fs_q;
        cfg_err_d = cfg_err_q;
        err_d     = err_q;
        pass_d    = pass_q;
        sv_d      = 1'b0;
        svec_d    = svec_q;
        szn_d     = szn_q;
        sexp_d    = sexp_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    fs_d      = bus.func_sel;
                    cfg_err_d = fn_illegal(bus.func_sel);
                    err_d     = '0;
                    pass_d    = 1'b0;
                    vec_d     = '0;
                    cnt_d     = '0;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CW'(SETTLE - 1)) state_d = ST_SAMPLE;
                else                          cnt_d   = cnt_q + 1'b1;
            end
            ST_SAMPLE: begin
                sv_d   = 1'b1;
                svec_d = vec_q;
                szn_d  = bus.dut_zn;
                sexp_d = exp_w;
                err_d  = err_q + (N_IN+1)'(mismatch);
                if (&vec_q) begin
                    pass_d  = (err_d == '0) & ~(cfg_err_q | illegal_w);
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            cnt_q     <= '0;
            fs_q      <= '0;
            cfg_err_q <= 1'b0;
            err_q     <= '0;
            pass_q    <= 1'b0;
            sv_q      <= 1'b0;
            svec_q    <= '0;
            szn_q     <= 1'b0;
            sexp_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            fs_q      <= fs_d;
            cfg_err_q <= cfg_err_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
            sv_q      <= sv_d;
            svec_q    <= svec_d;
            szn_q     <= szn_d;
            sexp_q    <= sexp_d;
        end
    end

    assign bus.vec_out      = vec_q;
    assign bus.busy         = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign bus.done         = (state_q == ST_DONE);
    assign bus.pass         = pass_q;
    assign bus.err_count    = err_q;
    assign bus.sample_valid = sv_q;
    assign bus.sample_vec   = svec_q;
    assign bus.sample_zn    = szn_q;
    assign bus.sample_exp   = sexp_q;
endmodule

// File: doc/gate_vector_sequencer.md
Name: gate_vector_sequencer

Overview:
- Synthesizable self-test driver that sits directly in front of a standard-cell gate under test (AND3_X1 class cells).
- Walks all 2^N_IN input vectors, drives them onto the cell inputs and waits a settle interval.
- Samples the cell output, compares it against a built-in reference function, and counts mismatches.
- Replaces hand-written per-vector stimulus and waits with one reusable clocked stage, usable in benches and on silicon test wrappers.

Parameters:
- N_IN, 3, number of gate inputs driven; legal range 1..6.
- SETTLE, 10, clock cycles a vector is held before sampling; minimum 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a run; honoured only in IDLE.
- func_sel  input  3  expected function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6–7 reserved. Latched at start.
- vec_out  output  N_IN  drives the DUT inputs; bit N_IN-1 is A1, bit 0 is the last input.
- dut_zn  input  1  DUT output, ZN.
- busy  output  1  high from the cycle after start until done.
- sample_valid  output  1  one-cycle pulse per vector checked.
- sample_vec  output  N_IN  vector just checked.
- sample_zn  output  1  sampled DUT value.
- sample_exp  output  1  reference value.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  run had zero mismatches and a legal func_sel; held until next start.
- err_count  output  N_IN+1  mismatch count; held until next start.

Behaviour:
- Reset is asynchronous: state=IDLE; all outputs 0, including vec_out, err_count and pass; internal counters 0.
- Reset mid-run aborts the run with no done pulse.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 latches func_sel, clears err_count, pass and cfg_err, loads vec_out=0 and settle_cnt=0, then moves to SETTLE.
  - Reserved func_sel sets cfg_err.
- SETTLE:
  - vec_out held stable.
  - settle_cnt increments each cycle; after SETTLE cycles in this state, move to SAMPLE.
- SAMPLE (1 cycle):
  - exp = f(func_sel_q, vec_out).
  - mismatch = (dut_zn !== exp), so X or Z on dut_zn counts as a failure; synthesis treats this as !=.
  - Registered on the edge leaving SAMPLE: sample_valid=1, sample_vec=vec_out, sample_zn=dut_zn, sample_exp=exp, err_count += mismatch.
  - Then:
    - if vec_out is all ones, go to DONE; vec_out keeps its value.
    - otherwise vec_out += 1, settle_cnt=0, and go to SETTLE.
- DONE (1 cycle):
  - done=1.
  - pass = (err_count==0) & ~cfg_err.
  - busy deasserts.
  - Next state is IDLE.
- start while busy or in DONE is ignored and not queued.
- start held high continuously restarts a run on each return to IDLE, one cycle after done.
- Reserved func_sel: exp is forced to 0, the run completes normally, pass=0.
- err_count never overflows: maximum 2^N_IN fits in N_IN+1 bits.
- Latency: start sampled at edge t0 → done high in cycle t0 + 2^N_IN·(SETTLE+1) + 1. For defaults this is t0+89.
- sample_valid for vector k rises at edge t0 + (k+1)·(SETTLE+1) + 1.
- vec_out sequence is strictly 0,1,…,2^N_IN−1 with no wrap-around; vec_out stays at all ones in IDLE after a run until the next start or reset.

Decomposition:
- Shared package gate_test_pkg:
  - func_sel code constants (FN_AND…FN_XNOR).
  - FSM state encoding.
  - Reference-function evaluation function, so benches reuse the same model.
- One sub-module, gate_ref_model: combinational, parameter N_IN; inputs func_sel and vec; outputs exp and illegal.

Test Plan:
1. N_IN=3, SETTLE=10, func_sel=0, DUT = ideal AND3_X1; pulse start → 8 sample_valid pulses with sample_exp 0,0,0,0,0,0,0,1; done at cycle 89; err_count=0; pass=1.
2. func_sel=0, DUT ZN tied to 0 (stuck-at-0) → one mismatch, at sample_vec=3'b111 (sample_zn=0, sample_exp=1); err_count=1; pass=0.
3. func_sel=1 (OR) against a real AND3_X1 → mismatches on vectors 001–110; err_count=6; pass=0.
4. Assert rst for one cycle during vector 4's SETTLE → vec_out, busy, err_count go 0 immediately (asynchronously); no done; a new start runs the full 89 cycles cleanly.
5. Extra start pulses during busy and during DONE → ignored; exactly one done pulse; err_count unaffected.
6. func_sel=7 with an ideal AND3_X1 → run completes in 89 cycles; sample_exp always 0; err_count=1; pass=0.
